// File: rtl/l2_bank_router_pkg.sv
// Shared definitions for the L2 bank router.
//   L2_BANK_BITS      : bank-select width for the default 4-bank build
//   bank_id_t         : bank index type for the default build
//   l2_flush_state_t  : flush sequencer states
//   l2_bank_index()   : line address -> bank index. With L2_BANK_XOR_EN
//                       defined, the select field is XOR-folded with the
//                       next field up so power-of-two strides spread
//                       across banks; otherwise it is a plain bit slice.
package l2_bank_router_pkg;

  localparam int L2_N_BANKS_DEF = 4;
  localparam int L2_BANK_BITS   = $clog2(L2_N_BANKS_DEF);
  localparam int L2_IDX_MAX     = 8;

  typedef logic [L2_BANK_BITS-1:0] bank_id_t;

  typedef enum logic [1:0] {IDLE, BCAST, WAIT, DONE} l2_flush_state_t;

  // off and bits are elaboration constants at every call site, so the
  // shifts reduce to wiring.
  function automatic logic [L2_IDX_MAX-1:0] l2_bank_index(
    input logic [63:0] addr,
    input int          off,
    input int          bits
  );
    logic [63:0]           lo;
    logic [63:0]           hi;
    logic [L2_IDX_MAX-1:0] r;
    lo = addr >> off;
    hi = addr >> (off + bits);
    r  = '0;
    for (int i = 0; i < L2_IDX_MAX; i++) begin
      if (i < bits) begin
`ifdef L2_BANK_XOR_EN
        r[i] = lo[i] ^ hi[i];
`else
        r[i] = lo[i];
`endif
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/l2_rr_arbiter.sv
// N-input locking round-robin arbiter.
//   req        : per-input valid
//   out_ready  : downstream ready
//   out_valid  : merged valid
//   grant_idx  : granted input index (held while locked)
//   grant_oh   : one-hot of the grant, zero when nothing is valid
// Handshake: a transfer happens on a cycle where out_valid && out_ready.
// Once out_valid is shown without ready, the grant locks until that
// transfer completes, so the merged payload cannot change underneath
// the consumer. After a transfer the search restarts one above the
// granted input.
module l2_rr_arbiter #(
  parameter  int N  = 4,
  localparam int BB = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [BB-1:0] grant_idx,
  output logic [N-1:0]  grant_oh
);

  logic [BB-1:0] rr_ptr;
  logic [BB-1:0] lock_idx;
  logic          lock;
  logic [BB-1:0] search_idx;
  logic [BB-1:0] cand;
  logic          found;

  // Upward search from rr_ptr; index arithmetic wraps because N is a
  // power of two.
  always_comb begin
    found      = 1'b0;
    search_idx = rr_ptr;
    cand       = rr_ptr;
    for (int i = 0; i < N; i++) begin
      cand = rr_ptr + BB'(i);
      if (!found && req[cand]) begin
        found      = 1'b1;
        search_idx = cand;
      end
    end
    grant_idx = lock ? lock_idx : search_idx;
    out_valid = lock ? req[lock_idx] : found;
    grant_oh  = out_valid ? (N'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (out_valid && out_ready) begin
      rr_ptr <= grant_idx + BB'(1);
      lock   <= 1'b0;
    end else if (out_valid) begin
      lock     <= 1'b1;
      lock_idx <= grant_idx;
    end
  end

endmodule

// File: rtl/l2_bank_router.sv
// Multi-bank L2 front end: one CPU request port fanned out to N_BANKS
// banks through a single-entry slice, bank req_out traffic merged onto
// one NoC port by a locking round-robin arbiter, and a flush broadcast
// that completes once every bank has reported done.
// Ports:
//   cpu_req_*        : upstream request (valid/ready)
//   bank_req_*       : per-bank valid/ready, shared addr/data
//   bank_out_*       : per-bank req_out, flattened payload
//   req_out_*        : merged req_out plus source bank
//   flush_valid/ready: flush request, accepted only from IDLE
//   bank_flush_*     : per-bank flush request/accept and done pulse
//   flush_done       : one-cycle completion pulse
//   dbg_flush_state  : flush sequencer state
// All valid/ready pairs: a transfer occurs on a cycle where both are
// high; a valid source holds its payload until that cycle.
// Build option: L2_BANK_XOR_EN selects XOR-folded bank hashing.
module l2_bank_router
  import l2_bank_router_pkg::*;
#(
  parameter int N_BANKS       = 4,
  parameter int ADDR_W        = 32,
  parameter int LINE_OFF_BITS = 4,
  parameter int REQ_W         = 96,
  parameter int OUT_W         = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_req_valid,
  output logic                         cpu_req_ready,
  input  logic [ADDR_W-1:0]            cpu_req_addr,
  input  logic [REQ_W-1:0]             cpu_req_data,
  output logic [N_BANKS-1:0]           bank_req_valid,
  input  logic [N_BANKS-1:0]           bank_req_ready,
  output logic [ADDR_W-1:0]            bank_req_addr,
  output logic [REQ_W-1:0]             bank_req_data,
  input  logic [N_BANKS-1:0]           bank_out_valid,
  output logic [N_BANKS-1:0]           bank_out_ready,
  input  logic [N_BANKS*OUT_W-1:0]     bank_out_data,
  output logic                         req_out_valid,
  input  logic                         req_out_ready,
  output logic [OUT_W-1:0]             req_out_data,
  output logic [$clog2(N_BANKS)-1:0]   req_out_bank,
  input  logic                         flush_valid,
  output logic                         flush_ready,
  output logic [N_BANKS-1:0]           bank_flush_valid,
  input  logic [N_BANKS-1:0]           bank_flush_ready,
  input  logic [N_BANKS-1:0]           bank_flush_done,
  output logic                         flush_done,
  output l2_flush_state_t              dbg_flush_state
);

  localparam int BB = $clog2(N_BANKS);

  // ---------------- request slice ----------------
  logic              full;
  logic [ADDR_W-1:0] addr_q;
  logic [REQ_W-1:0]  data_q;
  logic [BB-1:0]     bank_q;
  logic [BB-1:0]     bank_new;
  logic              drain;
  logic              accept;
  l2_flush_state_t   state;
  l2_flush_state_t   state_n;

  assign bank_new = BB'(l2_bank_index(64'(cpu_req_addr), LINE_OFF_BITS, BB));
  assign drain    = full && bank_req_ready[bank_q];
  // New requests are held off during a flush; an entry already in the
  // slice keeps draining.
  assign cpu_req_ready = (state == IDLE) && (!full || bank_req_ready[bank_q]);
  assign accept        = cpu_req_valid && cpu_req_ready;

  assign bank_req_valid = full ? (N_BANKS'(1) << bank_q) : '0;
  assign bank_req_addr  = addr_q;
  assign bank_req_data  = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      bank_q <= '0;
    end else if (accept) begin
      full   <= 1'b1;
      addr_q <= cpu_req_addr;
      data_q <= cpu_req_data;
      bank_q <= bank_new;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

  // ---------------- req_out merge ----------------
  logic [N_BANKS-1:0] grant_oh;
  logic [BB-1:0]      grant_idx;

  l2_rr_arbiter #(.N(N_BANKS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bank_out_valid),
    .out_ready (req_out_ready),
    .out_valid (req_out_valid),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh)
  );

  assign bank_out_ready = req_out_ready ? grant_oh : '0;
  assign req_out_data   = bank_out_data[grant_idx*OUT_W +: OUT_W];
  assign req_out_bank   = grant_idx;

  // ---------------- flush sequencer ----------------
  logic [N_BANKS-1:0] pend;
  logic [N_BANKS-1:0] pend_n;
  logic [N_BANKS-1:0] mask;
  logic [N_BANKS-1:0] mask_n;

  assign dbg_flush_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pend  <= '0;
      mask  <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      mask  <= mask_n;
    end
  end

  // Done pulses are collected from BCAST onward, since a fast bank may
  // finish before a slower one has even accepted its flush.
  always_comb begin
    state_n          = state;
    pend_n           = pend;
    mask_n           = mask;
    flush_ready      = 1'b0;
    bank_flush_valid = '0;
    flush_done       = 1'b0;
    case (state)
      IDLE: begin
        if (flush_valid) begin
          flush_ready = 1'b1;
          pend_n      = '1;
          state_n     = BCAST;
        end
      end
      BCAST: begin
        bank_flush_valid = pend;
        pend_n           = pend & ~bank_flush_ready;
        mask_n           = mask | bank_flush_done;
        if (pend_n == '0) state_n = WAIT;
      end
      WAIT: begin
        mask_n = mask | bank_flush_done;
        if (mask_n == '1) state_n = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        mask_n     = '0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
